// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data RAM (2^ADDR_W words of 32 bits, one-cycle
// synchronous read) between the CPU MEM stage and a debug/loader port.
// Every access takes three cycles: IDLE (arbitrate and latch), ACCESS (one RAM
// strobe), DONE (one-cycle ack to the winner with read data and error flag).
//
// The CPU wins by default. A bounded-wait counter forces a pending debug
// request through after MAX_WAIT consecutive CPU grants, so debug cannot
// starve behind a busy CPU.
//
// Supported accesses: word load, sign-extended halfword load (CPU only) and
// word store. Out-of-range and misaligned accesses are acked with err=1 and
// rdata=0, and never strobe the RAM.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   cpu_req/we/lh   CPU request, store select, halfword-load select
//   cpu_addr/wdata  CPU byte address and store data
//   cpu_ack/rdata   one-cycle completion pulse, load result (0 when no ack)
//   cpu_err         access rejected (valid with cpu_ack)
//   cpu_stall       cpu_req & ~cpu_ack
//   dbg_req/we      debug request and store select (word accesses only)
//   dbg_addr/wdata  debug byte address and store data
//   dbg_ack/rdata   one-cycle completion pulse, load result (0 when no ack)
//   dbg_err         access rejected (valid with dbg_ack)
//   ram_addr        RAM word address (latched byte address [ADDR_W+1:2])
//   ram_din         RAM store data
//   ram_str/ram_ld  RAM write / read strobes, high for exactly the ACCESS cycle
//   ram_dout        RAM read data, valid the cycle after ram_ld
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lh,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t              state_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [CNT_W-1:0]    wait_cnt_next;

  logic                sel_dbg_reg;   // 1 = debug owns the current access
  logic                we_reg;
  logic                lh_reg;
  logic                half_hi_reg;   // LH selects upper halfword (addr[1])
  logic                err_reg;

  logic                cpu_ack_reg;
  logic                cpu_err_reg;
  logic                dbg_ack_reg;
  logic                dbg_err_reg;
  logic                ram_str_reg;
  logic                ram_ld_reg;
  logic [ADDR_W-1:0]   ram_addr_reg;
  logic [31:0]         ram_din_reg;

  // ---------------------------------------------------------------------------
  // Arbitration and selected-request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic        any_req;
  logic        dbg_win;
  logic        sel_we;
  logic        sel_lh;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        range_err;
  logic        align_err;
  logic        sel_err;

  assign any_req = cpu_req | dbg_req;

  // Debug wins when it is alone, or when the CPU has used up its allowance.
  assign dbg_win = dbg_req & (~cpu_req | (wait_cnt_reg == MAX_CNT));

  // The debug port only does word accesses; LH is meaningless for stores.
  assign sel_we    = dbg_win ? dbg_we    : cpu_we;
  assign sel_lh    = dbg_win ? 1'b0      : (cpu_lh & ~cpu_we);
  assign sel_addr  = dbg_win ? dbg_addr  : cpu_addr;
  assign sel_wdata = dbg_win ? dbg_wdata : cpu_wdata;

  // Any address bit above the RAM byte space makes the access out of range.
  if (ADDR_W + 2 < 32) begin : g_range_chk
    assign range_err = |sel_addr[31:ADDR_W+2];
  end else begin : g_no_range_chk
    assign range_err = 1'b0;
  end

  // Words need 4-byte alignment, halfwords need 2-byte alignment.
  assign align_err = sel_lh ? sel_addr[0] : (|sel_addr[1:0]);
  assign sel_err   = range_err | align_err;

  // Bounded-wait counter: counts CPU grants made while debug is waiting.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_reg == IDLE) begin
      if (!dbg_req || dbg_win) begin
        wait_cnt_next = '0;
      end else if (cpu_req && (wait_cnt_reg != MAX_CNT)) begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: all control outputs are registered here
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      sel_dbg_reg  <= 1'b0;
      we_reg       <= 1'b0;
      lh_reg       <= 1'b0;
      half_hi_reg  <= 1'b0;
      err_reg      <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      cpu_err_reg  <= 1'b0;
      dbg_ack_reg  <= 1'b0;
      dbg_err_reg  <= 1'b0;
      ram_str_reg  <= 1'b0;
      ram_ld_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
    end else begin
      // Pulses default low so each is high for exactly one cycle.
      cpu_ack_reg  <= 1'b0;
      cpu_err_reg  <= 1'b0;
      dbg_ack_reg  <= 1'b0;
      dbg_err_reg  <= 1'b0;
      ram_str_reg  <= 1'b0;
      ram_ld_reg   <= 1'b0;
      wait_cnt_reg <= wait_cnt_next;

      unique case (state_reg)
        IDLE: begin
          if (any_req) begin
            sel_dbg_reg  <= dbg_win;
            we_reg       <= sel_we;
            lh_reg       <= sel_lh;
            half_hi_reg  <= sel_addr[1];
            err_reg      <= sel_err;
            ram_addr_reg <= sel_addr[ADDR_W+1:2];
            ram_din_reg  <= sel_wdata;
            // Strobes become visible in the ACCESS cycle; rejected accesses
            // never touch the RAM.
            ram_ld_reg   <= ~sel_we & ~sel_err;
            ram_str_reg  <= sel_we & ~sel_err;
            state_reg    <= ACCESS;
          end
        end

        ACCESS: begin
          if (sel_dbg_reg) begin
            dbg_ack_reg <= 1'b1;
            dbg_err_reg <= err_reg;
          end else begin
            cpu_ack_reg <= 1'b1;
            cpu_err_reg <= err_reg;
          end
          state_reg <= DONE;
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data formatting. ram_dout is valid during DONE (one cycle after the
  // ACCESS-cycle ram_ld), which is exactly when the ack is high, so the result
  // is steered combinationally and gated by the ack.
  // ---------------------------------------------------------------------------
  logic [15:0] half_sel;
  logic [31:0] lh_word;
  logic [31:0] fmt_data;
  logic        rd_valid;

  assign half_sel = half_hi_reg ? ram_dout[31:16] : ram_dout[15:0];

  for (genvar gi = 0; gi < 32; gi++) begin : g_sext
    if (gi < 16) begin : g_lo
      assign lh_word[gi] = half_sel[gi];
    end else begin : g_hi
      assign lh_word[gi] = half_sel[15];
    end
  end

  assign fmt_data = lh_reg ? lh_word : ram_dout;

  // Only successful loads return data; stores and errors return zero.
  assign rd_valid = ~we_reg & ~err_reg;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cpu_ack   = cpu_ack_reg;
  assign cpu_err   = cpu_err_reg;
  assign cpu_rdata = (cpu_ack_reg & rd_valid) ? fmt_data : 32'd0;
  assign cpu_stall = cpu_req & ~cpu_ack_reg;

  assign dbg_ack   = dbg_ack_reg;
  assign dbg_err   = dbg_err_reg;
  assign dbg_rdata = (dbg_ack_reg & rd_valid) ? fmt_data : 32'd0;

  assign ram_addr  = ram_addr_reg;
  assign ram_din   = ram_din_reg;
  assign ram_str   = ram_str_reg;
  assign ram_ld    = ram_ld_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives dmem_arbiter against a behavioural single-port RAM with registered
// read. Single accesses come from a table of {request, expected result}
// records; expected results go into a scoreboard queue when the request is
// driven and are popped by a monitor when an ack appears. Hand-written
// sequences cover arbitration fairness and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, cpu_lh;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic              cpu_ack, cpu_err, cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              dbg_req, dbg_we;
  logic [31:0]       dbg_addr, dbg_wdata;
  logic              dbg_ack, dbg_err;
  logic [31:0]       dbg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_str, ram_ld;
  logic [31:0]       ram_dout;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lh(cpu_lh),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_str(ram_str), .ram_ld(ram_ld), .ram_dout(ram_dout)
  );

  // Behavioural RAM: write on strobe, registered read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    ram_dout = 32'd0;
  end
  always @(posedge clk) begin
    if (ram_str) mem[ram_addr] <= ram_din;
    if (ram_ld)  ram_dout <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int vec_cnt     = 0;
  int miscompares = 0;

  typedef struct {
    bit          dbg;
    bit          err;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          dbg;
    bit          we;
    bit          lh;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: mid-cycle sampling, one line per completed access.
  always @(negedge clk) begin
    if (cpu_ack || dbg_ack) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        miscompares++;
        $display("FAIL unexpected_ack: cpu_ack=%0b dbg_ack=%0b with nothing pending at %0t",
                 cpu_ack, dbg_ack, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("ack %s err=%0b rdata=0x%08h", dbg_ack ? "DBG" : "CPU",
                 dbg_ack ? dbg_err : cpu_err, dbg_ack ? dbg_rdata : cpu_rdata);
        chk("ack_owner_dbg", {31'd0, dbg_ack}, {31'd0, e.dbg});
        chk("ack_owner_cpu", {31'd0, cpu_ack}, {31'd0, !e.dbg});
        if (e.dbg) begin
          chk("dbg_err",   {31'd0, dbg_err}, {31'd0, e.err});
          chk("dbg_rdata", dbg_rdata, e.rd);
          chk("cpu_rdata_quiet", cpu_rdata, 32'd0);
        end else begin
          chk("cpu_err",   {31'd0, cpu_err}, {31'd0, e.err});
          chk("cpu_rdata", cpu_rdata, e.rd);
          chk("dbg_rdata_quiet", dbg_rdata, 32'd0);
        end
      end
    end else begin
      chk("cpu_rdata_no_ack", cpu_rdata, 32'd0);
      chk("dbg_rdata_no_ack", dbg_rdata, 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // One isolated access from IDLE, with cycle-exact checks. Entered and left
  // 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic do_access(input vec_t v);
    exp_t e;
    logic exp_ld, exp_str;
    e.dbg = v.dbg; e.err = v.err; e.rd = v.rd;
    sb.push_back(e);
    exp_ld  = !v.we && !v.err;
    exp_str = v.we && !v.err;

    if (v.dbg) begin
      dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = v.we; cpu_lh = v.lh; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
    end
    #1;
    if (!v.dbg) chk("stall_idle", {31'd0, cpu_stall}, 32'd1);

    @(posedge clk); #1;   // ACCESS cycle
    chk("access_ram_ld",  {31'd0, ram_ld},  {31'd0, exp_ld});
    chk("access_ram_str", {31'd0, ram_str}, {31'd0, exp_str});
    if (!v.err) chk("access_ram_addr", {22'd0, ram_addr}, {22'd0, v.addr[ADDR_W+1:2]});
    if (exp_str) chk("access_ram_din", ram_din, v.wdata);
    if (!v.dbg) chk("stall_access", {31'd0, cpu_stall}, 32'd1);
    chk("access_no_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);

    @(posedge clk); #1;   // DONE cycle
    if (v.dbg) begin
      chk("done_dbg_ack", {31'd0, dbg_ack}, 32'd1);
      chk("done_cpu_quiet", {31'd0, cpu_ack}, 32'd0);
    end else begin
      chk("done_cpu_ack", {31'd0, cpu_ack}, 32'd1);
      chk("done_dbg_quiet", {31'd0, dbg_ack}, 32'd0);
      chk("stall_done", {31'd0, cpu_stall}, 32'd0);
    end
    chk("done_no_strobe", {30'd0, ram_ld, ram_str}, 32'd0);
    cpu_req = 1'b0;
    dbg_req = 1'b0;

    @(posedge clk); #1;   // back in IDLE
    chk("idle_no_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
  endtask

  // Waits (bounded) for the next ack while requests are held; the monitor
  // checks who got it and the data.
  task automatic wait_grant(input bit exp_dbg, input logic [31:0] exp_rd, input string tag);
    exp_t e;
    int   n;
    bit   got;
    e.dbg = exp_dbg; e.err = 1'b0; e.rd = exp_rd;
    sb.push_back(e);
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ack || dbg_ack) got = 1'b1;
    end
    if (!got) begin
      vec_cnt++;
      miscompares++;
      $display("FAIL grant_timeout_%s: no ack within 12 cycles, expected %s", tag,
               exp_dbg ? "DBG" : "CPU");
      void'(sb.pop_back());
    end
  endtask

  function automatic vec_t mk(bit dbg, bit we, bit lh, logic [31:0] addr,
                              logic [31:0] wdata, bit err, logic [31:0] rd);
    vec_t v;
    v.dbg = dbg; v.we = we; v.lh = lh; v.addr = addr;
    v.wdata = wdata; v.err = err; v.rd = rd;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t vecs[19];

  initial begin
    //            dbg we lh addr          wdata         err rdata
    vecs[0]  = mk(0, 1, 0, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0000_0010, 32'h0,        0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 0, 32'h0000_0020, 32'h80017FFF, 0, 32'h0);
    vecs[3]  = mk(0, 0, 1, 32'h0000_0020, 32'h0,        0, 32'h00007FFF);
    vecs[4]  = mk(0, 0, 1, 32'h0000_0022, 32'h0,        0, 32'hFFFF8001);
    vecs[5]  = mk(0, 0, 1, 32'h0000_0021, 32'h0,        1, 32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0000_1000, 32'h0,        1, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0000_0004, 32'hA5A55A5A, 0, 32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h0000_0006, 32'h11111111, 1, 32'h0);
    vecs[9]  = mk(0, 0, 0, 32'h0000_0004, 32'h0,        0, 32'hA5A55A5A);
    vecs[10] = mk(1, 1, 0, 32'h0000_0000, 32'h12345678, 0, 32'h0);
    vecs[11] = mk(1, 0, 0, 32'h0000_0000, 32'h0,        0, 32'h12345678);
    vecs[12] = mk(0, 0, 0, 32'h0000_0002, 32'h0,        1, 32'h0);
    vecs[13] = mk(1, 0, 0, 32'h0000_0020, 32'h0,        0, 32'h80017FFF);
    vecs[14] = mk(0, 1, 0, 32'h0000_0FFC, 32'hCAFEF00D, 0, 32'h0);
    vecs[15] = mk(0, 0, 1, 32'h0000_0FFE, 32'h0,        0, 32'hFFFFCAFE);
    vecs[16] = mk(0, 0, 1, 32'h0000_0FFC, 32'h0,        0, 32'hFFFFF00D);
    vecs[17] = mk(0, 1, 1, 32'h0000_0032, 32'h22222222, 1, 32'h0);
    vecs[18] = mk(1, 0, 0, 32'h8000_0000, 32'h0,        1, 32'h0);

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_lh = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acks",     {30'd0, cpu_ack, dbg_ack}, 32'd0);
    chk("rst_errs",     {30'd0, cpu_err, dbg_err}, 32'd0);
    chk("rst_strobes",  {30'd0, ram_ld, ram_str},  32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_din",  ram_din, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven single accesses
    for (int i = 0; i < 19; i++) do_access(vecs[i]);

    // Rejected store at 0x6 must have left word 1 alone (checked by vecs[9]);
    // also confirm directly in the RAM model.
    chk("mem_word1_intact", mem[1], 32'hA5A55A5A);

    // Arbitration: both requesters held. Two CPU grants, then debug drops for
    // one grant (clearing the wait counter), then returns.
    cpu_we = 0; cpu_lh = 0; cpu_addr = 32'h10;
    dbg_we = 0; dbg_addr = 32'h0;
    cpu_req = 1'b1; dbg_req = 1'b1;
    wait_grant(0, 32'hDEADBEEF, "a0");
    wait_grant(0, 32'hDEADBEEF, "a1");
    dbg_req = 1'b0;
    wait_grant(0, 32'hDEADBEEF, "a2");
    dbg_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < MAX_WAIT; c++) wait_grant(0, 32'hDEADBEEF, "cpu_run");
      wait_grant(1, 32'h12345678, "dbg_forced");
    end
    wait_grant(0, 32'hDEADBEEF, "after_dbg");
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arb_quiet", {30'd0, cpu_ack, dbg_ack}, 32'd0);

    // Reset asserted during ACCESS of a CPU store.
    cpu_we = 1; cpu_lh = 0; cpu_addr = 32'h40; cpu_wdata = 32'h55AA55AA;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_str_before", {31'd0, ram_str}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_str_async", {31'd0, ram_str}, 32'd0);
    chk("rstmid_ram_addr",  {22'd0, ram_addr}, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rstmid_no_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    end
    chk("rstmid_mem_untouched", mem[16], 32'd0);
    do_access(mk(0, 0, 0, 32'h40, 32'h0, 0, 32'h0));
    do_access(mk(0, 1, 0, 32'h40, 32'h55AA55AA, 0, 32'h0));
    do_access(mk(0, 0, 0, 32'h40, 32'h0, 0, 32'h55AA55AA));

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data RAM, 2^ADDR_W x 32, 1-cycle synchronous read, between two requesters.
- Requesters: the CPU MEM stage and a debug/loader port.
- Performs word and sign-extended halfword (LH) reads, plus word stores.
- Stalls the CPU while its access is pending, and prevents debug starvation with a bounded-wait counter.

Parameters:
ADDR_W, 10, RAM word-address width; RAM byte space is 2^(ADDR_W+2).
MAX_WAIT, 4, consecutive CPU grants tolerated while dbg_req is pending before debug is forced through (>=1).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
cpu_we  in  1  1 = store word, 0 = load
cpu_lh  in  1  load halfword, sign-extended (ignored when cpu_we=1)
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  load result, valid only while cpu_ack=1
cpu_err  out  1  with cpu_ack: access rejected
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
dbg_req  in  1  debug request; same hold rule
dbg_we  in  1  1 = store word, 0 = load word
dbg_addr  in  32  byte address
dbg_wdata  in  32  store data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  32  word read result, valid with dbg_ack
dbg_err  out  1  with dbg_ack: access rejected
ram_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2]
ram_din  out  32  store data to RAM
ram_str  out  1  RAM write strobe
ram_ld  out  1  RAM read strobe
ram_dout  in  32  RAM read data; valid the cycle after ram_ld

Behaviour:
- Reset (async): state=IDLE, wait_cnt=0.
  - All outputs 0: acks, errs, rdata, ram_str, ram_ld, ram_addr, ram_din.
  - Reset mid-access drops the strobes immediately; no ack is issued. The requester must re-request.
- FSM states: IDLE, ACCESS, DONE. One access per 3 cycles.
  - IDLE: if any req, select the winner and latch we/lh/addr/wdata/requester id, then go to ACCESS. With no req, stay in IDLE.
  - ACCESS: registered ram_ld=~we and ram_str=we for exactly one cycle; go to DONE.
    - For an error access, both strobes stay 0.
  - DONE: pulse the winner's ack for one cycle with rdata/err; go to IDLE.
  - Latency: req high at edge k -> ACCESS in cycle k+1 -> ack in cycle k+2.
  - The acked requester must drop or change req by the next edge. A req still high in IDLE counts as a new request.
- Arbitration, evaluated only in IDLE:
  - CPU wins by default.
  - Debug wins if only dbg_req is high, or if both are high and wait_cnt==MAX_WAIT.
  - wait_cnt increments on each CPU grant made while dbg_req=1, saturating at MAX_WAIT.
  - wait_cnt clears on a debug grant, and in any IDLE cycle where dbg_req=0.
- Error rules (err=1, rdata=0, no RAM strobe, normal ack timing):
  - addr[31:ADDR_W+2] != 0.
  - Word access with addr[1:0] != 0.
  - LH with addr[0]=1.
- Read data formatting in DONE:
  - Word: rdata = ram_dout.
  - LH with addr[1]=0: sign-extend ram_dout[15:0].
  - LH with addr[1]=1: sign-extend ram_dout[31:16].
- cpu_rdata/dbg_rdata are 0 whenever their ack is 0. Only the winner's ack/rdata/err move.
- A store followed by a load to the same address returns the stored value. There is no forwarding; ordering comes from serialization.

Test Plan:
1. Reset, then CPU store 0xDEADBEEF @0x10, then CPU load @0x10. Required:
   - Store: ram_str=1 with ram_addr=4 in cycle k+1; cpu_ack at k+2.
   - Load: cpu_rdata=0xDEADBEEF; cpu_stall high exactly 2 cycles per access.
2. Word 0x8001_7FFF @0x20. Required:
   - LH @0x20 -> 0x00007FFF.
   - LH @0x22 -> 0xFFFF8001.
   - LH @0x21 -> cpu_err=1, rdata=0, no ram_ld.
3. Out-of-range and misaligned addresses (ADDR_W=10). Required:
   - Load @0x1000 -> err=1, no strobes.
   - Word store @0x0006 -> err=1, RAM contents unchanged.
4. cpu_req and dbg_req held continuously, MAX_WAIT=4. Required: grant order CPU,CPU,CPU,CPU,DBG,CPU..., with wait_cnt back to 0 after the DBG grant.
5. Only dbg_req: debug store 0x12345678 @0x0, then debug load @0x0. Required:
   - dbg_rdata=0x12345678.
   - cpu_ack stays 0 throughout.
6. Assert rst during ACCESS of a CPU store. Required:
   - ram_str falls asynchronously; no cpu_ack.
   - State returns to IDLE; a re-issued request completes normally 2 cycles after its IDLE edge.
